// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - animated 16-bit LED pattern source with valid/ready output
module led_pattern_gen #(
   parameter logic [31:0] DIV = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  mode,
   input  logic        word_ready,
   output logic [15:0] led_word,
   output logic        word_valid
);

   localparam logic [31:0] LP_CNT_LAST = DIV - 32'd1;

   localparam logic [1:0]  LP_MODE_ROTATE   = 2'd0;
   localparam logic [1:0]  LP_MODE_PINGPONG = 2'd1;
   localparam logic [1:0]  LP_MODE_COUNT    = 2'd2;
   localparam logic [1:0]  LP_MODE_BLINK    = 2'd3;

   localparam logic [15:0] LP_RESET_WORD    = 16'h0001;

   // Prescaler and pending-tick state
   logic [31:0] r_cnt;
   logic        r_pend;

   // Pattern state: the visible word doubles as the animation state
   logic [1:0]  r_mode_q;
   logic        r_dir;
   logic [15:0] r_led_word;
   logic        r_word_valid;

   logic        w_tick;
   logic        w_slot_free;
   logic        w_step;
   logic        w_xfer;
   logic        w_mode_change;
   logic [15:0] w_seed_word;
   logic [15:0] w_adv_word;
   logic        w_adv_dir;

   // The output register can take a new word when empty or being emptied this cycle,
   // which is what lets a pending tick land in the same cycle as a transfer.
   assign w_tick        = enable & (r_cnt == LP_CNT_LAST);
   assign w_slot_free   = ~r_word_valid | word_ready;
   assign w_step        = enable & (w_tick | r_pend) & w_slot_free;
   assign w_xfer        = r_word_valid & word_ready;
   assign w_mode_change = (mode != r_mode_q);

   // Prescaler: free-runs while enabled, wraps on tick, parks at zero when stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!enable || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end

   // Pending tick: remembers a single tick that could not step; extra ticks are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= 1'b0;
      end else if (!enable || w_step) begin
         r_pend <= 1'b0;
      end else if (w_tick) begin
         r_pend <= 1'b1;
      end
   end

   // Seed word for the mode being switched into
   always_comb begin
      w_seed_word = 16'h0001;
      case (mode)
         LP_MODE_ROTATE:   w_seed_word = 16'h0001;
         LP_MODE_PINGPONG: w_seed_word = 16'h0001;
         LP_MODE_COUNT:    w_seed_word = 16'h0000;
         LP_MODE_BLINK:    w_seed_word = 16'hFFFF;
         default:          w_seed_word = 16'h0001;
      endcase
   end

   // Next pattern word and ping-pong direction under the current mode
   always_comb begin
      w_adv_word = r_led_word;
      w_adv_dir  = r_dir;
      case (r_mode_q)
         LP_MODE_ROTATE: begin
            w_adv_word = {r_led_word[14:0], r_led_word[15]};
         end
         LP_MODE_PINGPONG: begin
            // Direction flips on reaching an end so each end is shown only once per sweep
            if (!r_dir) begin
               w_adv_word = {r_led_word[14:0], 1'b0};
               w_adv_dir  = w_adv_word[15];
            end else begin
               w_adv_word = {1'b0, r_led_word[15:1]};
               w_adv_dir  = ~w_adv_word[0];
            end
         end
         LP_MODE_COUNT: begin
            w_adv_word = r_led_word + 16'd1;
         end
         LP_MODE_BLINK: begin
            w_adv_word = ~r_led_word;
         end
         default: begin
            w_adv_word = r_led_word;
         end
      endcase
   end

   // Mode tracking: a mode change is only acted on at a step, where it reseeds the pattern
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_q <= LP_MODE_ROTATE;
         r_dir    <= 1'b0;
      end else if (w_step) begin
         if (w_mode_change) begin
            r_mode_q <= mode;
            r_dir    <= 1'b0;
         end else begin
            r_dir    <= w_adv_dir;
         end
      end
   end

   // Output word and valid: load on step, drop valid after a transfer with no new step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led_word   <= LP_RESET_WORD;
         r_word_valid <= 1'b0;
      end else if (w_step) begin
         r_led_word   <= w_mode_change ? w_seed_word : w_adv_word;
         r_word_valid <= 1'b1;
      end else if (w_xfer) begin
         r_word_valid <= 1'b0;
      end
   end

   assign led_word   = r_led_word;
   assign word_valid = r_word_valid;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic        word_ready = 1'b0;
   logic [15:0] word4, word1;
   logic        valid4, valid1;

   int checks = 0;
   int errors = 0;
   bit sb_on  = 1'b0;

   always #5 clk = ~clk;

   led_pattern_gen #(.DIV(32'd4)) u_div4 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .word_ready(word_ready), .led_word(word4), .word_valid(valid4)
   );

   led_pattern_gen #(.DIV(32'd1)) u_div1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
      .word_ready(word_ready), .led_word(word1), .word_valid(valid1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pattern = function(mode, number of steps since that mode was entered).
   localparam int M_DIV [2] = '{4, 1};
   int         m_cnt  [2] = '{0, 0};
   bit         m_pend [2] = '{0, 0};
   bit         m_valid[2] = '{0, 0};
   logic [1:0] m_mq   [2] = '{2'd0, 2'd0};
   int         m_idx  [2] = '{0, 0};

   function automatic logic [15:0] pat(input logic [1:0] md, input int idx);
      int p;
      case (md)
         2'd0: return 16'h0001 << (idx % 16);
         2'd1: begin
            p = idx % 30;
            return (p <= 15) ? (16'h0001 << p) : (16'h0001 << (30 - p));
         end
         2'd2: return 16'(idx % 65536);
         default: return (idx % 2 == 0) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   function automatic bit f_tick(input int k);
      return enable && (m_cnt[k] == M_DIV[k] - 1);
   endfunction

   function automatic bit f_step(input int k);
      return enable && (f_tick(k) || m_pend[k]) && (!m_valid[k] || word_ready);
   endfunction

   // model state update on the same edges as the DUT
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_cnt[k] <= 0; m_pend[k] <= 1'b0; m_valid[k] <= 1'b0;
            m_mq[k] <= 2'd0; m_idx[k] <= 0;
         end else begin
            m_cnt[k]  <= (!enable || f_tick(k)) ? 0 : m_cnt[k] + 1;
            m_pend[k] <= !enable ? 1'b0 : f_step(k) ? 1'b0 : f_tick(k) ? 1'b1 : m_pend[k];
            if (f_step(k)) begin
               if (mode != m_mq[k]) begin
                  m_mq[k]  <= mode;
                  m_idx[k] <= 0;
               end else begin
                  m_idx[k] <= m_idx[k] + 1;
               end
               m_valid[k] <= 1'b1;
            end else if (m_valid[k] && word_ready) begin
               m_valid[k] <= 1'b0;
            end
         end
      end
   end

   // scoreboard compare, away from the active edge
   always @(negedge clk) begin
      if (sb_on) begin
         check("sb_div4", {15'd0, valid4, word4}, {15'd0, m_valid[0], pat(m_mq[0], m_idx[0])});
         check("sb_div1", {15'd0, valid1, word1}, {15'd0, m_valid[1], pat(m_mq[1], m_idx[1])});
      end
   end

   // ---------------- stimulus helpers ----------------
   // cyc leaves time at 1 unit after a rising edge; inputs are driven 1 unit later
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; enable = 1'b0; word_ready = 1'b0; mode = 2'd0;
      cyc(2); #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] word;
      int          gap;
   } vec_t;

   vec_t tbl[$];
   logic [15:0] pp[32];
   int n;

   initial begin
      // table: rotate sequence, then switch into blink, then into count
      for (int i = 2; i <= 16; i++) tbl.push_back('{2'd0, 16'h0001 << (i % 16), 4});
      tbl.push_back('{2'd3, 16'hFFFF, 4});
      tbl.push_back('{2'd3, 16'h0000, 4});
      tbl.push_back('{2'd3, 16'hFFFF, 4});
      tbl.push_back('{2'd2, 16'h0000, 4});
      tbl.push_back('{2'd2, 16'h0001, 4});
      tbl.push_back('{2'd2, 16'h0002, 4});

      // reset values
      cyc(2);
      check("rst_word4",  word4,  16'h0001);
      check("rst_valid4", valid4, 1'b0);
      check("rst_word1",  word1,  16'h0001);
      check("rst_valid1", valid1, 1'b0);
      #1; rst_n = 1'b1;
      sb_on = 1'b1;

      // latency from enable, then rotate table
      enable = 1'b1; mode = 2'd0; word_ready = 1'b1;
      for (int e = 0; e < 3; e++) begin
         cyc(1);
         check("en_latency_lo", valid4, 1'b0);
      end
      cyc(1);
      check("en_latency_hi", valid4, 1'b1);
      check("rot_first", word4, 16'h0002);
      foreach (tbl[i]) begin
         #1; mode = tbl[i].mode;
         cyc(1);
         check("pulse_width", valid4, 1'b0);
         n = 1;
         while (!valid4 && n < 12) begin cyc(1); n++; end
         check("vec_gap", n, tbl[i].gap);
         check("vec_word", word4, tbl[i].word);
      end

      // asynchronous reset mid-handshake, no clock edge involved
      #1; rst_n = 1'b0;
      #1;
      check("async_rst_word",  word4,  16'h0001);
      check("async_rst_valid", valid4, 1'b0);
      cyc(1); #1; rst_n = 1'b1;

      // ping-pong on DIV=1
      do_reset();
      enable = 1'b1; mode = 2'd1; word_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         cyc(1);
         pp[i] = word1;
         check("pp_valid", valid1, 1'b1);
      end
      check("pp_first", pp[0],  16'h0001);
      check("pp_top",   pp[15], 16'h8000);
      check("pp_back",  pp[16], 16'h4000);
      check("pp_home",  pp[30], 16'h0001);
      check("pp_again", pp[31], 16'h0002);

      // backpressure on DIV=4, mode 2
      do_reset();
      enable = 1'b1; mode = 2'd2; word_ready = 1'b1;
      n = 0;
      while (!(valid4 && word4 == 16'h0001) && n < 20) begin cyc(1); n++; end
      check("bp_reach_one", word4, 16'h0001);
      #1; word_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         check("bp_hold", {valid4, word4}, {1'b1, 16'h0001});
      end
      #1; word_ready = 1'b1;
      cyc(1); #1; word_ready = 1'b0;
      check("bp_next", {valid4, word4}, {1'b1, 16'h0002});
      cyc(4);
      check("bp_hold2", {valid4, word4}, {1'b1, 16'h0002});
      #1; word_ready = 1'b1;
      cyc(1);
      check("bp_pend_word", {valid4, word4}, {1'b1, 16'h0003});
      cyc(1);
      check("bp_one_pend", valid4, 1'b0);
      cyc(1);
      check("bp_tick_word", {valid4, word4}, {1'b1, 16'h0004});

      // count wrap and switch to blink on DIV=1
      do_reset();
      enable = 1'b1; mode = 2'd2; word_ready = 1'b1;
      n = 0;
      while (!(valid1 && word1 == 16'hFFFF) && n < 70000) begin cyc(1); n++; end
      check("wrap_reach", word1, 16'hFFFF);
      cyc(1);
      check("wrap_zero", word1, 16'h0000);
      #1; mode = 2'd3;
      cyc(1); check("blink_seed", word1, 16'hFFFF);
      cyc(1); check("blink_inv1", word1, 16'h0000);
      cyc(1); check("blink_inv2", word1, 16'hFFFF);

      // enable low with a word waiting
      do_reset();
      enable = 1'b1; mode = 2'd0; word_ready = 1'b0;
      cyc(4);
      check("en_word", {valid4, word4}, {1'b1, 16'h0002});
      #1; enable = 1'b0;
      cyc(6);
      check("en_off_hold", {valid4, word4}, {1'b1, 16'h0002});
      #1; word_ready = 1'b1;
      cyc(1);
      check("en_off_taken", valid4, 1'b0);
      cyc(3);
      check("en_off_idle", valid4, 1'b0);
      #1; enable = 1'b1;
      for (int e = 0; e < 3; e++) begin
         cyc(1);
         check("en_back_lo", valid4, 1'b0);
      end
      cyc(1);
      check("en_back_hi", {valid4, word4}, {1'b1, 16'h0004});

      // randomized run against the model, with occasional async resets
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         enable     = ($urandom_range(0, 9) != 0);
         word_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            #1;
            check("rnd_async_rst", {valid4, word4, valid1, word1},
                  {1'b0, 16'h0001, 1'b0, 16'h0001});
            cyc(1); #1;
            rst_n = 1'b1;
         end
         cyc(1); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
